// File: rtl/nibble_sequence_matcher.sv
// Registered detector for a programmable sequence of 4-bit digits, with a
// match pulse, a progress index and a saturating match counter.
module nibble_sequence_matcher #(
  parameter int N_DIGITS = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [3:0]       key_in,
  input  logic             din_valid,
  input  logic [3:0]       din,
  output logic             match,
  output logic [2:0]       progress,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [2:0] LAST_IDX = 3'(N_DIGITS - 1);

  logic [3:0]       key [N_DIGITS];
  logic [2:0]       idx;
  logic             match_q;
  logic [CNT_W-1:0] count_q;
  logic [3:0]       key_sel;
  logic             eq;
  logic             eq_first;
  logic             count_full;

  // Select the digit expected next; idx never exceeds N_DIGITS-1.
  always_comb begin
    key_sel = key[0];
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == 3'(i)) key_sel = key[i];
    end
  end

  assign eq         = (din == key_sel);
  assign eq_first   = (din == key[0]);
  assign count_full = &count_q;

  // Key shift register: new digits enter at the top, oldest ends in key[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) key[i] <= 4'd0;
    end else if (key_load) begin
      for (int i = 0; i < N_DIGITS - 1; i++) key[i] <= key[i+1];
      key[N_DIGITS-1] <= key_in;
    end
  end

  // Matching index, pulse and counter; a key load restarts matching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= 3'd0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      match_q <= 1'b0;
      if (key_load) begin
        idx <= 3'd0;
      end else if (din_valid) begin
        if (eq && idx == LAST_IDX) begin
          idx     <= 3'd0;
          match_q <= 1'b1;
          if (!count_full) count_q <= count_q + 1'b1;
        end else if (eq) begin
          idx <= idx + 3'd1;
        end else begin
          idx <= eq_first ? 3'd1 : 3'd0;
        end
      end
    end
  end

  assign match       = match_q;
  assign progress    = idx;
  assign match_count = count_q;

endmodule

// File: tb/tb_nibble_sequence_matcher.sv
// Directed bench for nibble_sequence_matcher: a 4-digit/8-bit instance and a
// 2-digit/2-bit instance, checked through a scoreboard of expected outputs.
module tb_nibble_sequence_matcher;

  typedef struct {
    string      tag;
    logic       m;
    logic [2:0] p;
    logic [7:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_load = 1'b0, key_load2 = 1'b0;
  logic [3:0] key_in = 4'd0, key_in2 = 4'd0;
  logic       din_valid = 1'b0, din_valid2 = 1'b0;
  logic [3:0] din = 4'd0, din2 = 4'd0;
  logic       match, match2;
  logic [2:0] progress, progress2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int tests = 0;
  int fails = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  nibble_sequence_matcher #(.N_DIGITS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .din_valid(din_valid), .din(din), .match(match),
    .progress(progress), .match_count(match_count)
  );

  nibble_sequence_matcher #(.N_DIGITS(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .key_load(key_load2), .key_in(key_in2),
    .din_valid(din_valid2), .din(din2), .match(match2),
    .progress(progress2), .match_count(match_count2)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the 4-digit instance: drive, queue expectation, check after edge.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic ld,
                               input logic [3:0] k, input logic em, input logic [2:0] ep,
                               input logic [7:0] ec, input string tag);
    exp_t e;
    din_valid = v; din = d; key_load = ld; key_in = k;
    q1.push_back('{tag, em, ep, ec});
    @(posedge clk); #1;
    e = q1.pop_front();
    checkOutput({e.tag, ".match"}, {7'd0, match}, {7'd0, e.m});
    checkOutput({e.tag, ".progress"}, {5'd0, progress}, {5'd0, e.p});
    checkOutput({e.tag, ".count"}, match_count, e.c);
  endtask

  task automatic applyStimulus2(input logic v, input logic [3:0] d, input logic ld,
                                input logic [3:0] k, input logic em, input logic [2:0] ep,
                                input logic [7:0] ec, input string tag);
    exp_t e;
    din_valid2 = v; din2 = d; key_load2 = ld; key_in2 = k;
    q2.push_back('{tag, em, ep, ec});
    @(posedge clk); #1;
    e = q2.pop_front();
    checkOutput({e.tag, ".match2"}, {7'd0, match2}, {7'd0, e.m});
    checkOutput({e.tag, ".progress2"}, {5'd0, progress2}, {5'd0, e.p});
    checkOutput({e.tag, ".count2"}, {6'd0, match_count2}, e.c);
  endtask

  initial begin
    #12;
    checkOutput("reset.match", {7'd0, match}, 8'd0);
    checkOutput("reset.progress", {5'd0, progress}, 8'd0);
    checkOutput("reset.count", match_count, 8'd0);
    rst = 1'b0;

    // Two-digit instance with a 2-bit counter: saturation at 3.
    applyStimulus2(0, 0, 1, 1, 0, 0, 0, "k2a");
    applyStimulus2(0, 0, 1, 2, 0, 0, 0, "k2b");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus2(1, 1, 0, 0, 0, 1, 8'(i - 1 > 3 ? 3 : i - 1), $sformatf("sat%0d.a", i));
      applyStimulus2(1, 2, 0, 0, 1, 0, 8'(i > 3 ? 3 : i), $sformatf("sat%0d.b", i));
    end
    applyStimulus2(0, 0, 0, 0, 0, 0, 3, "sat.idle");

    // Load key 3,7,7,2 and match it straight through.
    applyStimulus(0, 0, 1, 3, 0, 0, 0, "load0");
    applyStimulus(0, 0, 1, 7, 0, 0, 0, "load1");
    applyStimulus(0, 0, 1, 7, 0, 0, 0, "load2");
    applyStimulus(0, 0, 1, 2, 0, 0, 0, "load3");
    applyStimulus(1, 3, 0, 0, 0, 1, 0, "t1.d0");
    applyStimulus(1, 7, 0, 0, 0, 2, 0, "t1.d1");
    applyStimulus(1, 7, 0, 0, 0, 3, 0, "t1.d2");
    applyStimulus(1, 2, 0, 0, 1, 0, 1, "t1.d3");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "t1.idle");

    // Restart on key[0] after a mismatch.
    applyStimulus(1, 3, 0, 0, 0, 1, 1, "t2.d0");
    applyStimulus(1, 7, 0, 0, 0, 2, 1, "t2.d1");
    applyStimulus(1, 3, 0, 0, 0, 1, 1, "t2.d2");
    applyStimulus(1, 7, 0, 0, 0, 2, 1, "t2.d3");
    applyStimulus(1, 7, 0, 0, 0, 3, 1, "t2.d4");
    applyStimulus(1, 2, 0, 0, 1, 0, 2, "t2.d5");
    applyStimulus(0, 0, 0, 0, 0, 0, 2, "t2.idle");

    // Back-to-back matches with a two-cycle valid gap in the second.
    applyStimulus(1, 3, 0, 0, 0, 1, 2, "t3.d0");
    applyStimulus(1, 7, 0, 0, 0, 2, 2, "t3.d1");
    applyStimulus(1, 7, 0, 0, 0, 3, 2, "t3.d2");
    applyStimulus(1, 2, 0, 0, 1, 0, 3, "t3.d3");
    applyStimulus(1, 3, 0, 0, 0, 1, 3, "t3.d4");
    applyStimulus(1, 7, 0, 0, 0, 2, 3, "t3.d5");
    applyStimulus(0, 5, 0, 0, 0, 2, 3, "t3.gap0");
    applyStimulus(0, 3, 0, 0, 0, 2, 3, "t3.gap1");
    applyStimulus(1, 7, 0, 0, 0, 3, 3, "t3.d6");
    applyStimulus(1, 2, 0, 0, 1, 0, 4, "t3.d7");

    // Key load mid-sequence resets progress; key becomes 7,7,2,9.
    applyStimulus(1, 3, 0, 0, 0, 1, 4, "t4.d0");
    applyStimulus(1, 7, 0, 0, 0, 2, 4, "t4.d1");
    applyStimulus(1, 7, 0, 0, 0, 3, 4, "t4.d2");
    applyStimulus(1, 2, 1, 9, 0, 0, 4, "t4.load");
    applyStimulus(1, 7, 0, 0, 0, 1, 4, "t4.n0");
    applyStimulus(1, 7, 0, 0, 0, 2, 4, "t4.n1");
    applyStimulus(1, 2, 0, 0, 0, 3, 4, "t4.n2");
    applyStimulus(1, 9, 0, 0, 1, 0, 5, "t4.n3");

    // Asynchronous reset in the middle of a stream.
    applyStimulus(1, 7, 0, 0, 0, 1, 5, "t5.d0");
    applyStimulus(1, 7, 0, 0, 0, 2, 5, "t5.d1");
    rst = 1'b1;
    #2;
    checkOutput("arst.match", {7'd0, match}, 8'd0);
    checkOutput("arst.progress", {5'd0, progress}, 8'd0);
    checkOutput("arst.count", match_count, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All-zero key after reset; a non-key[0] mismatch drops to 0.
    applyStimulus(1, 0, 0, 0, 0, 1, 0, "t6.z0");
    applyStimulus(1, 5, 0, 0, 0, 0, 0, "t6.miss");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, "t6.d0");
    applyStimulus(1, 0, 0, 0, 0, 2, 0, "t6.d1");
    applyStimulus(1, 0, 0, 0, 0, 3, 0, "t6.d2");
    applyStimulus(1, 0, 0, 0, 1, 0, 1, "t6.d3");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "t6.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
